lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
Load/store sequencer for the MEM stage of the MIPS pipeline. It takes the effective address from the address-generation unit plus the access size. It then checks alignment, drives a valid/ready data-memory port with byte enables, and waits for load data. It returns extended load data or an address/bus exception, and stalls the pipeline while an access is outstanding.

Parameters:
TIMEOUT_CYCLES, 255, max cycles in ISSUE+WAIT before bus-error; counter width = $clog2(TIMEOUT_CYCLES+1)

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  reset, asynchronous, active-low
i_req_valid  in  1  EX/MEM presents a memory op
o_req_ready  out  1  high only in IDLE
i_is_store  in  1  1=store, 0=load
i_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
i_sign_ext  in  1  loads: 1=sign-extend, 0=zero-extend
i_eff_addr  in  32  effective byte address from the address-generation unit
i_store_data  in  32  store operand (low bits used for byte/half)
i_flush  in  1  kill current/incoming op
o_mem_valid  out  1  memory request valid
i_mem_ready  in  1  memory accepts request
o_mem_we  out  1  write enable
o_mem_addr  out  32  word address {addr[31:2],2'b00}
o_mem_be  out  4  byte enables, little-endian
o_mem_wdata  out  32  lane-replicated store data
i_mem_rvalid  in  1  load data valid
i_mem_rdata  in  32  load data word
o_done  out  1  one-cycle completion pulse
o_stall  out  1  high whenever state != IDLE
o_load_data  out  32  extended load result, held until next done
o_exc  out  2  00 none, 01 load addr error, 10 store addr error, 11 bus timeout
o_bad_addr  out  32  faulting address when o_exc != 00

Behaviour:
- Reset (async, i_rst_n=0): state IDLE, o_req_ready=1; all other outputs 0; timeout counter and discard flag cleared.
- States: IDLE, ISSUE, WAIT, DISCARD.
- IDLE: accept when i_req_valid && !i_flush. Latch is_store, size, sign_ext, addr, store data; clear o_exc.
- Alignment at accept: half requires addr[0]=0; word requires addr[1:0]=00. On misalign: no memory access. Next cycle o_done=1, o_exc=01 (load) or 10 (store), o_bad_addr=addr; stay IDLE.
- Aligned accept -> ISSUE. o_mem_valid=1; addr/be/we/wdata stay stable until i_mem_ready=1.
- Byte enables: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111.
- wdata: byte {4{d[7:0]}}; half {2{d[15:0]}}; word d.
- Store handshake: ISSUE -> IDLE; o_done=1 next cycle. Minimum store latency is 2 cycles from accept to o_done.
- Load handshake: ISSUE -> WAIT. i_mem_rvalid is only honoured in WAIT; rvalid in the handshake cycle is ignored.
- Load data return: WAIT with rvalid -> select lane by addr[1:0] (half by addr[1]), extend per sign_ext, register into o_load_data, o_done=1, -> IDLE. Minimum load latency is 3 cycles.
- Timeout: counter resets on accept and increments each cycle in ISSUE/WAIT. On reaching TIMEOUT_CYCLES: o_exc=11, o_bad_addr=addr, o_done=1, -> IDLE. In WAIT, a timeout -> DISCARD instead of IDLE.
- Flush in ISSUE before handshake: drop the op, -> IDLE, no o_done.
- Flush in ISSUE during handshake, or in WAIT: -> DISCARD.
- DISCARD: absorb one rvalid without updating o_load_data and without o_done, then -> IDLE. Store-flush at handshake goes straight to IDLE (the write is committed).
- Simultaneous flush+rvalid in WAIT: the response is discarded, no done, -> IDLE.
- o_exc and o_bad_addr are sticky until the next accept. o_done is never high in two consecutive cycles.

Decomposition:
- Shared defs package lsu_defs: size codes, exc codes, state encoding.
- Combinational sub-module lsu_lane: inputs size/addr[1:0]/store data/rdata/sign_ext; outputs be, wdata, extended load data.
- lsu_ctrl holds the FSM, counter and registers.

Test Plan:
- Store word 0x1000, data 0xDEADBEEF, ready immediate -> be=1111, wdata=DEADBEEF, addr 0x1000, done 2 cycles after accept, exc=00.
- Load byte 0x1003 sign_ext=1, rdata 0x80FF_0000 -> be=1000, o_load_data=0xFFFF_FF80; sign_ext=0 -> 0x0000_0080.
- Load half at 0x2001 -> no mem_valid, done next cycle, exc=01, bad_addr=0x2001. Store word at 0x2002 -> exc=10.
- Load word, i_mem_ready held low, TIMEOUT_CYCLES=4 -> exc=11 and done after 4 cycles in ISSUE; o_mem_valid stays high throughout with stable addr.
- Load in WAIT, flush, rvalid 2 cycles later -> no done, o_load_data unchanged; new request accepted after DISCARD exits.
- Reset asserted mid-WAIT -> outputs zero immediately, o_req_ready=1, next load completes normally.

Source files
------------

// File: rtl/lsu_defs_pkg.sv
// rtl/lsu_defs_pkg.sv - shared size, exception and state codes for the load/store unit
package lsu_defs;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] EXC_NONE       = 2'b00;
  localparam logic [1:0] EXC_LOAD_ADDR  = 2'b01;
  localparam logic [1:0] EXC_STORE_ADDR = 2'b10;
  localparam logic [1:0] EXC_TIMEOUT    = 2'b11;

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_ISSUE   = 2'b01;
  localparam logic [1:0] ST_WAIT    = 2'b10;
  localparam logic [1:0] ST_DISCARD = 2'b11;

  // Size code 11 behaves exactly like a word access.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic m;
    case (size)
      SZ_BYTE: m = 1'b0;
      SZ_HALF: m = addr_lo[0];
      default: m = (addr_lo != 2'b00);
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// rtl/lsu_lane.sv - byte-lane steering: byte enables, store replication, load extraction/extension
module lsu_lane
  import lsu_defs::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_rdata,
  input  logic        i_sign_ext,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_be        = 4'b1111;
    o_wdata     = i_store_data;
    o_load_data = i_rdata;
    case (i_size)
      SZ_BYTE: begin
        o_be        = 4'b0001 << i_addr_lo;
        o_wdata     = {4{i_store_data[7:0]}};
        o_load_data = {{24{i_sign_ext & w_byte[7]}}, w_byte};
      end
      SZ_HALF: begin
        o_be        = 4'b0011 << {i_addr_lo[1], 1'b0};
        o_wdata     = {2{i_store_data[15:0]}};
        o_load_data = {{16{i_sign_ext & w_half[15]}}, w_half};
      end
      default: begin
        o_be        = 4'b1111;
        o_wdata     = i_store_data;
        o_load_data = i_rdata;
      end
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - MEM-stage load/store sequencer with alignment check, bus timeout and flush
module lsu_ctrl
  import lsu_defs::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_is_store,
  input  logic [1:0]  i_size,
  input  logic        i_sign_ext,
  input  logic [31:0] i_eff_addr,
  input  logic [31:0] i_store_data,
  input  logic        i_flush,
  output logic        o_mem_valid,
  input  logic        i_mem_ready,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_be,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata,
  output logic        o_done,
  output logic        o_stall,
  output logic [31:0] o_load_data,
  output logic [1:0]  o_exc,
  output logic [31:0] o_bad_addr
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    r_state;
  logic          r_is_store;
  logic          r_sign_ext;
  logic          r_done;
  logic [1:0]    r_size;
  logic [1:0]    r_exc;
  logic [31:0]   r_addr;
  logic [31:0]   r_sdata;
  logic [31:0]   r_bad_addr;
  logic [31:0]   r_load_data;
  logic [CW-1:0] r_cnt;

  logic          w_ready;
  logic          w_accept;
  logic          w_issue;
  logic          w_timeout;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic [31:0]   w_ext;

  // Ready drops in the done cycle so back-to-back completions never merge into one pulse.
  assign w_ready   = (r_state == ST_IDLE) && !r_done;
  assign w_accept  = w_ready && i_req_valid && !i_flush;
  assign w_issue   = (r_state == ST_ISSUE);
  assign w_timeout = (r_cnt >= CW'(TIMEOUT_CYCLES - 1));

  lsu_lane u_lane (
    .i_size       (r_size),
    .i_addr_lo    (r_addr[1:0]),
    .i_store_data (r_sdata),
    .i_rdata      (i_mem_rdata),
    .i_sign_ext   (r_sign_ext),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_load_data  (w_ext)
  );

  assign o_req_ready = w_ready;
  assign o_stall     = (r_state != ST_IDLE);
  assign o_mem_valid = w_issue;
  assign o_mem_we    = w_issue & r_is_store;
  assign o_mem_addr  = w_issue ? {r_addr[31:2], 2'b00} : 32'h0;
  assign o_mem_be    = w_issue ? w_be : 4'h0;
  assign o_mem_wdata = w_issue ? w_wdata : 32'h0;
  assign o_done      = r_done;
  assign o_load_data = r_load_data;
  assign o_exc       = r_exc;
  assign o_bad_addr  = r_bad_addr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_is_store  <= 1'b0;
      r_sign_ext  <= 1'b0;
      r_done      <= 1'b0;
      r_size      <= 2'b00;
      r_exc       <= EXC_NONE;
      r_addr      <= 32'h0;
      r_sdata     <= 32'h0;
      r_bad_addr  <= 32'h0;
      r_load_data <= 32'h0;
      r_cnt       <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_state == ST_ISSUE || r_state == ST_WAIT) begin
        if (r_cnt != CW'(TIMEOUT_CYCLES)) r_cnt <= r_cnt + CW'(1);
      end
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_is_store <= i_is_store;
            r_size     <= i_size;
            r_sign_ext <= i_sign_ext;
            r_addr     <= i_eff_addr;
            r_sdata    <= i_store_data;
            r_cnt      <= '0;
            r_exc      <= EXC_NONE;
            r_bad_addr <= 32'h0;
            if (misaligned(i_size, i_eff_addr[1:0])) begin
              r_done     <= 1'b1;
              r_exc      <= i_is_store ? EXC_STORE_ADDR : EXC_LOAD_ADDR;
              r_bad_addr <= i_eff_addr;
            end else begin
              r_state <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          // A flushed store that handshakes is already committed; a flushed load must eat its response.
          if (i_flush) begin
            r_state <= (i_mem_ready && !r_is_store) ? ST_DISCARD : ST_IDLE;
          end else if (i_mem_ready) begin
            r_state <= r_is_store ? ST_IDLE : ST_WAIT;
            r_done  <= r_is_store;
          end else if (w_timeout) begin
            r_state    <= ST_IDLE;
            r_done     <= 1'b1;
            r_exc      <= EXC_TIMEOUT;
            r_bad_addr <= r_addr;
          end
        end
        ST_WAIT: begin
          if (i_flush) begin
            r_state <= i_mem_rvalid ? ST_IDLE : ST_DISCARD;
          end else if (i_mem_rvalid) begin
            r_state     <= ST_IDLE;
            r_done      <= 1'b1;
            r_load_data <= w_ext;
          end else if (w_timeout) begin
            r_state    <= ST_DISCARD;
            r_done     <= 1'b1;
            r_exc      <= EXC_TIMEOUT;
            r_bad_addr <= r_addr;
          end
        end
        default: begin
          if (i_mem_rvalid) r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - self-checking bench for lsu_ctrl with a byte-lane reference model
module tb_lsu_ctrl;

  localparam int TO = 4;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_is_store;
  logic [1:0]  i_size;
  logic        i_sign_ext;
  logic [31:0] i_eff_addr;
  logic [31:0] i_store_data;
  logic        i_flush;
  logic        o_mem_valid;
  logic        i_mem_ready;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [3:0]  o_mem_be;
  logic [31:0] o_mem_wdata;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;
  logic        o_done;
  logic        o_stall;
  logic [31:0] o_load_data;
  logic [1:0]  o_exc;
  logic [31:0] o_bad_addr;

  lsu_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_is_store(i_is_store), .i_size(i_size), .i_sign_ext(i_sign_ext), .i_eff_addr(i_eff_addr),
    .i_store_data(i_store_data), .i_flush(i_flush), .o_mem_valid(o_mem_valid), .i_mem_ready(i_mem_ready),
    .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_be(o_mem_be), .o_mem_wdata(o_mem_wdata),
    .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata), .o_done(o_done), .o_stall(o_stall),
    .o_load_data(o_load_data), .o_exc(o_exc), .o_bad_addr(o_bad_addr)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int failures = 0;
  logic [31:0] m_load = 32'h0;

  int          ob_lat;
  int          ob_vcnt;
  logic        ob_done;
  logic        ob_saw;
  logic        ob_stable;
  logic        ob_we;
  logic [3:0]  ob_be;
  logic [31:0] ob_addr;
  logic [31:0] ob_wdata;

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [1:0] lo);
    logic [3:0] be;
    be = 4'h0;
    for (int i = 0; i < 4; i++) be[i] = (i >= int'(lo)) && (i < int'(lo) + nbytes(sz));
    return be;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] v;
    v = 32'h0;
    for (int i = 0; i < 4; i++) v[8*i +: 8] = d[8*(i % nbytes(sz)) +: 8];
    return v;
  endfunction

  function automatic logic [31:0] m_extract(input logic [1:0] sz, input logic [1:0] lo,
                                            input logic sx, input logic [31:0] w);
    logic [31:0] v;
    int n;
    n = nbytes(sz);
    v = 32'h0;
    for (int k = 0; k < n; k++) v[8*k +: 8] = w[8*(int'(lo) + k) +: 8];
    if (sx && v[8*n-1]) for (int b = 8*n; b < 32; b++) v[b] = 1'b1;
    return v;
  endfunction

  // Drives one request and plays memory: ready after rdy_dly valid cycles, rvalid after rv_dly wait cycles.
  task automatic run_op(input logic st, input logic [1:0] sz, input logic sx, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] rword, input int rdy_dly, input int rv_dly);
    int vc;
    int wc;
    logic hs;
    vc = 0; wc = 0; hs = 1'b0;
    ob_done = 1'b0; ob_saw = 1'b0; ob_stable = 1'b1; ob_lat = 0; ob_vcnt = 0;
    ob_we = 1'b0; ob_be = 4'h0; ob_addr = 32'h0; ob_wdata = 32'h0;
    i_req_valid = 1'b1; i_is_store = st; i_size = sz; i_sign_ext = sx;
    i_eff_addr = a; i_store_data = d;
    for (int c = 1; c <= 40 && !ob_done; c++) begin
      @(negedge i_clk);
      i_req_valid = 1'b0;
      i_is_store = 1'($urandom); i_size = 2'($urandom); i_sign_ext = 1'($urandom);
      i_eff_addr = $urandom; i_store_data = $urandom;
      i_mem_ready = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = $urandom;
      ob_lat = c;
      if (o_done) begin
        ob_done = 1'b1;
      end else if (o_mem_valid) begin
        if (!ob_saw) begin
          ob_saw = 1'b1; ob_be = o_mem_be; ob_addr = o_mem_addr; ob_wdata = o_mem_wdata; ob_we = o_mem_we;
        end else if ({o_mem_be, o_mem_addr, o_mem_wdata, o_mem_we} !== {ob_be, ob_addr, ob_wdata, ob_we}) begin
          ob_stable = 1'b0;
        end
        ob_vcnt++;
        if (vc >= rdy_dly) begin
          i_mem_ready = 1'b1; hs = 1'b1;
          i_mem_rvalid = 1'b1; i_mem_rdata = ~rword;
        end
        vc++;
      end else if (hs && !st) begin
        if (wc >= rv_dly) begin
          i_mem_rvalid = 1'b1; i_mem_rdata = rword;
        end
        wc++;
      end
    end
    i_mem_ready = 1'b0; i_mem_rvalid = 1'b0;
  endtask

  task automatic test_reset;
    i_rst_n = 1'b0;
    repeat (2) @(negedge i_clk);
    checks++;
    if ({o_req_ready, o_mem_valid, o_mem_we, o_done, o_stall} !== 5'b10000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=10000", {o_req_ready, o_mem_valid, o_mem_we, o_done, o_stall});
    end
    checks++;
    if ({o_mem_addr, o_mem_be, o_mem_wdata, o_load_data, o_exc, o_bad_addr} !== '0) begin
      failures++;
      $display("FAIL reset_data addr=%h be=%h wd=%h ld=%h exc=%0d bad=%h exp=all zero",
               o_mem_addr, o_mem_be, o_mem_wdata, o_load_data, o_exc, o_bad_addr);
    end
    i_rst_n = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic test_store_word;
    run_op(1'b1, 2'b10, 1'b0, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0, 0, 0);
    checks++;
    if (!ob_done || ob_lat != 2) begin
      failures++; $display("FAIL sw_latency done=%0d lat=%0d exp=1/2", ob_done, ob_lat);
    end
    checks++;
    if ({ob_be, ob_we, ob_addr, ob_wdata} !== {4'hF, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF}) begin
      failures++;
      $display("FAIL sw_port be=%b we=%b addr=%h wd=%h exp=1111/1/00001000/deadbeef", ob_be, ob_we, ob_addr, ob_wdata);
    end
    checks++;
    if (o_exc !== 2'b00) begin
      failures++; $display("FAIL sw_exc got=%0d exp=0", o_exc);
    end
    @(negedge i_clk);
    checks++;
    if (o_done !== 1'b0) begin
      failures++; $display("FAIL sw_done_pulse got=%b exp=0", o_done);
    end
  endtask

  task automatic test_load_byte;
    run_op(1'b0, 2'b00, 1'b1, 32'h0000_1003, 32'h0, 32'h80FF_0000, 0, 0);
    checks++;
    if (!ob_done || ob_lat != 3 || ob_be !== 4'b1000 || ob_we !== 1'b0) begin
      failures++;
      $display("FAIL lb_port done=%0d lat=%0d be=%b we=%b exp=1/3/1000/0", ob_done, ob_lat, ob_be, ob_we);
    end
    checks++;
    if (o_load_data !== 32'hFFFF_FF80) begin
      failures++; $display("FAIL lb_sext got=%h exp=ffffff80", o_load_data);
    end
    @(negedge i_clk);
    run_op(1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0, 32'h80FF_0000, 0, 0);
    m_load = 32'h0000_0080;
    checks++;
    if (o_load_data !== 32'h0000_0080) begin
      failures++; $display("FAIL lb_zext got=%h exp=00000080", o_load_data);
    end
    @(negedge i_clk);
  endtask

  task automatic test_misaligned;
    run_op(1'b0, 2'b01, 1'b0, 32'h0000_2001, 32'h0, 32'h0, 0, 0);
    checks++;
    if (!ob_done || ob_lat != 1 || ob_saw || o_exc !== 2'b01 || o_bad_addr !== 32'h0000_2001) begin
      failures++;
      $display("FAIL mis_load done=%0d lat=%0d memv=%0d exc=%0d bad=%h exp=1/1/0/1/00002001",
               ob_done, ob_lat, ob_saw, o_exc, o_bad_addr);
    end
    @(negedge i_clk);
    run_op(1'b1, 2'b10, 1'b0, 32'h0000_2002, 32'h1234_5678, 32'h0, 0, 0);
    checks++;
    if (!ob_done || ob_lat != 1 || ob_saw || o_exc !== 2'b10 || o_bad_addr !== 32'h0000_2002) begin
      failures++;
      $display("FAIL mis_store done=%0d lat=%0d memv=%0d exc=%0d bad=%h exp=1/1/0/2/00002002",
               ob_done, ob_lat, ob_saw, o_exc, o_bad_addr);
    end
    @(negedge i_clk);
  endtask

  task automatic test_timeout;
    run_op(1'b0, 2'b10, 1'b0, 32'h0000_0A40, 32'h0, 32'h0, 100, 0);
    checks++;
    if (!ob_done || ob_lat != TO + 1 || ob_vcnt != TO || !ob_stable || ob_addr !== 32'h0000_0A40) begin
      failures++;
      $display("FAIL timeout_issue done=%0d lat=%0d vcyc=%0d stable=%0d addr=%h exp=1/%0d/%0d/1/00000a40",
               ob_done, ob_lat, ob_vcnt, ob_stable, ob_addr, TO + 1, TO);
    end
    checks++;
    if (o_exc !== 2'b11 || o_bad_addr !== 32'h0000_0A40 || o_load_data !== m_load) begin
      failures++;
      $display("FAIL timeout_exc exc=%0d bad=%h ld=%h exp=3/00000a40/%h", o_exc, o_bad_addr, o_load_data, m_load);
    end
    @(negedge i_clk);
  endtask

  task automatic test_flush_issue;
    i_req_valid = 1'b1; i_is_store = 1'b0; i_size = 2'b10; i_eff_addr = 32'h0000_4000;
    @(negedge i_clk);
    i_req_valid = 1'b0;
    checks++;
    if (o_mem_valid !== 1'b1) begin
      failures++; $display("FAIL fi_issue got=%b exp=1", o_mem_valid);
    end
    i_flush = 1'b1;
    @(negedge i_clk);
    i_flush = 1'b0;
    checks++;
    if ({o_mem_valid, o_done, o_req_ready, o_stall} !== 4'b0010) begin
      failures++;
      $display("FAIL fi_drop got=%b exp=0010", {o_mem_valid, o_done, o_req_ready, o_stall});
    end
  endtask

  task automatic test_flush_wait;
    i_req_valid = 1'b1; i_is_store = 1'b0; i_size = 2'b10; i_eff_addr = 32'h0000_3000;
    @(negedge i_clk);
    i_req_valid = 1'b0; i_mem_ready = 1'b1;
    @(negedge i_clk);
    i_mem_ready = 1'b0;
    checks++;
    if ({o_stall, o_mem_valid} !== 2'b10) begin
      failures++; $display("FAIL fw_in_wait got=%b exp=10", {o_stall, o_mem_valid});
    end
    i_flush = 1'b1;
    @(negedge i_clk);
    i_flush = 1'b0;
    @(negedge i_clk);
    checks++;
    if ({o_done, o_req_ready} !== 2'b00) begin
      failures++; $display("FAIL fw_discard got=%b exp=00", {o_done, o_req_ready});
    end
    i_mem_rvalid = 1'b1; i_mem_rdata = 32'h1234_5678;
    @(negedge i_clk);
    i_mem_rvalid = 1'b0;
    checks++;
    if ({o_done, o_req_ready} !== 2'b01 || o_load_data !== m_load) begin
      failures++;
      $display("FAIL fw_exit done/ready=%b ld=%h exp=01/%h", {o_done, o_req_ready}, o_load_data, m_load);
    end
    i_req_valid = 1'b1; i_is_store = 1'b0; i_size = 2'b01; i_eff_addr = 32'h0000_3002;
    @(negedge i_clk);
    i_req_valid = 1'b0; i_mem_ready = 1'b1;
    @(negedge i_clk);
    i_mem_ready = 1'b0; i_flush = 1'b1; i_mem_rvalid = 1'b1; i_mem_rdata = 32'hAAAA_5555;
    @(negedge i_clk);
    i_flush = 1'b0; i_mem_rvalid = 1'b0;
    checks++;
    if ({o_done, o_req_ready} !== 2'b01 || o_load_data !== m_load) begin
      failures++;
      $display("FAIL fw_flush_rvalid done/ready=%b ld=%h exp=01/%h", {o_done, o_req_ready}, o_load_data, m_load);
    end
    run_op(1'b0, 2'b01, 1'b1, 32'h0000_3002, 32'h0, 32'hBEEF_1234, 1, 1);
    m_load = 32'hFFFF_BEEF;
    checks++;
    if (!ob_done || ob_lat != 5 || o_load_data !== m_load) begin
      failures++;
      $display("FAIL fw_after done=%0d lat=%0d ld=%h exp=1/5/%h", ob_done, ob_lat, o_load_data, m_load);
    end
    @(negedge i_clk);
  endtask

  task automatic test_reset_mid_wait;
    i_req_valid = 1'b1; i_is_store = 1'b0; i_size = 2'b10; i_eff_addr = 32'h0000_5000;
    @(negedge i_clk);
    i_req_valid = 1'b0; i_mem_ready = 1'b1;
    @(negedge i_clk);
    i_mem_ready = 1'b0;
    #2 i_rst_n = 1'b0;
    #1;
    checks++;
    if ({o_req_ready, o_stall, o_done, o_mem_valid} !== 4'b1000 || o_load_data !== 32'h0 ||
        o_exc !== 2'b00 || o_bad_addr !== 32'h0) begin
      failures++;
      $display("FAIL rst_mid ctl=%b ld=%h exc=%0d bad=%h exp=1000/0/0/0",
               {o_req_ready, o_stall, o_done, o_mem_valid}, o_load_data, o_exc, o_bad_addr);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    m_load = 32'h0;
    run_op(1'b0, 2'b10, 1'b0, 32'h0000_5004, 32'h0, 32'hC001_D00D, 0, 0);
    m_load = 32'hC001_D00D;
    checks++;
    if (!ob_done || ob_lat != 3 || o_load_data !== m_load) begin
      failures++;
      $display("FAIL rst_after done=%0d lat=%0d ld=%h exp=1/3/%h", ob_done, ob_lat, o_load_data, m_load);
    end
    @(negedge i_clk);
  endtask

  task automatic test_random;
    logic st, sx, mis, iss_to, wait_to;
    logic [1:0] sz, exc;
    logic [31:0] a, d, rw;
    int rd, rv, lat, twait;
    for (int it = 0; it < 60; it++) begin
      st = 1'($urandom); sx = 1'($urandom); sz = 2'($urandom);
      a = $urandom; d = $urandom; rw = $urandom;
      rd = $urandom_range(0, 3); rv = $urandom_range(0, 3);
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        else if (sz != 2'b00) a[1:0] = 2'b00;
      end
      mis = (int'(a[1:0]) % nbytes(sz)) != 0;
      iss_to = (rd + 1 > TO);
      twait = (rd + 2 > TO) ? rd + 2 : TO;
      wait_to = !mis && !iss_to && !st && (rv >= 1) && (twait <= rd + rv + 1);
      if (mis) begin exc = st ? 2'b10 : 2'b01; lat = 1; end
      else if (iss_to) begin exc = 2'b11; lat = TO + 1; end
      else if (st) begin exc = 2'b00; lat = rd + 2; end
      else if (wait_to) begin exc = 2'b11; lat = twait + 1; end
      else begin exc = 2'b00; lat = rd + rv + 3; end
      run_op(st, sz, sx, a, d, rw, rd, rv);
      if (!mis && !st && exc == 2'b00) m_load = m_extract(sz, a[1:0], sx, rw);
      checks++;
      if (!ob_done || ob_lat != lat) begin
        failures++;
        $display("FAIL rnd_lat it=%0d done=%0d got=%0d exp=%0d", it, ob_done, ob_lat, lat);
      end
      checks++;
      if (o_exc !== exc || (exc != 2'b00 && o_bad_addr !== a)) begin
        failures++;
        $display("FAIL rnd_exc it=%0d exc=%0d bad=%h exp=%0d/%h", it, o_exc, o_bad_addr, exc, a);
      end
      checks++;
      if (o_load_data !== m_load) begin
        failures++; $display("FAIL rnd_load it=%0d got=%h exp=%h", it, o_load_data, m_load);
      end
      checks++;
      if (mis ? ob_saw : (!ob_saw || !ob_stable || ob_be !== m_be(sz, a[1:0]) ||
                          ob_addr !== {a[31:2], 2'b00} || ob_we !== st ||
                          (st && ob_wdata !== m_wdata(sz, d)))) begin
        failures++;
        $display("FAIL rnd_port it=%0d saw=%0d stable=%0d be=%b addr=%h we=%b wd=%h exp_be=%b exp_wd=%h",
                 it, ob_saw, ob_stable, ob_be, ob_addr, ob_we, ob_wdata, m_be(sz, a[1:0]), m_wdata(sz, d));
      end
      @(negedge i_clk);
      checks++;
      if (o_done !== 1'b0 || o_req_ready !== !wait_to) begin
        failures++;
        $display("FAIL rnd_after it=%0d done=%b ready=%b exp=0/%b", it, o_done, o_req_ready, !wait_to);
      end
      if (wait_to) begin
        i_mem_rvalid = 1'b1; i_mem_rdata = $urandom;
        @(negedge i_clk);
        i_mem_rvalid = 1'b0;
        checks++;
        if ({o_done, o_req_ready} !== 2'b01 || o_load_data !== m_load) begin
          failures++;
          $display("FAIL rnd_discard it=%0d done/ready=%b ld=%h exp=01/%h", it, {o_done, o_req_ready}, o_load_data, m_load);
        end
      end
    end
  endtask

  initial begin
    i_rst_n = 1'b0; i_req_valid = 1'b0; i_is_store = 1'b0; i_size = 2'b00; i_sign_ext = 1'b0;
    i_eff_addr = 32'h0; i_store_data = 32'h0; i_flush = 1'b0; i_mem_ready = 1'b0;
    i_mem_rvalid = 1'b0; i_mem_rdata = 32'h0;
    test_reset;
    test_store_word;
    test_load_byte;
    test_misaligned;
    test_timeout;
    test_flush_issue;
    test_flush_wait;
    test_reset_mid_wait;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
